// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types and default sizes for the neuron weight sequencer.
// A weight set bundles the three synaptic weights with their dendrite enables.
package neuron_pkg;

  localparam int WSEQ_WIDTH   = 4;
  localparam int WSEQ_DEPTH   = 8;
  localparam int WSEQ_DWELL_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // de[0] drives DE1, de[1] drives DE2, de[2] drives DE3
  typedef struct packed {
    logic [WSEQ_WIDTH-1:0] w1;
    logic [WSEQ_WIDTH-1:0] w2;
    logic [WSEQ_WIDTH-1:0] w3;
    logic [2:0]            de;
  } wset_t;

endpackage

// File: rtl/weight_set_mem.sv
// weight_set_mem: DEPTH x wset_t register file, one synchronous write port and
// one asynchronous read port. The sequencer registers whatever it reads, so
// the combinational read path ends in its output flops.
module weight_set_mem
  import neuron_pkg::*;
#(
  parameter int DEPTH = WSEQ_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          Clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  wset_t         wr_data,
  input  logic [AW-1:0] rd_addr,
  output wset_t         rd_data
);

  wset_t mem [DEPTH];

  // Write the offered weight set; contents are never reset.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/neuron_weight_sequencer.sv
// neuron_weight_sequencer: loads weight sets while idle, then replays them to
// the neuron stage, holding each set for max(Dwell,1) cycles.
// Build option: define NEURON_WSEQ_LOOP_EN to make playback wrap to entry 0
// (pulsing Step and Done together) until Stop or reset, instead of ending.
// The wset_t field width is fixed by neuron_pkg, so WIDTH must match WSEQ_WIDTH.
module neuron_weight_sequencer
  import neuron_pkg::*;
#(
  parameter int WIDTH   = WSEQ_WIDTH,
  parameter int DEPTH   = WSEQ_DEPTH,
  parameter int DWELL_W = WSEQ_DWELL_W
) (
  input  logic                     Clk,
  input  logic                     Rst_n,
  input  logic                     Ld_valid,
  output logic                     Ld_ready,
  input  logic [WIDTH-1:0]         Ld_w1,
  input  logic [WIDTH-1:0]         Ld_w2,
  input  logic [WIDTH-1:0]         Ld_w3,
  input  logic [2:0]               Ld_de,
  input  logic                     Clear,
  input  logic                     Start,
  input  logic                     Stop,
  input  logic [DWELL_W-1:0]       Dwell,
  output logic [WIDTH-1:0]         W1,
  output logic [WIDTH-1:0]         W2,
  output logic [WIDTH-1:0]         W3,
  output logic                     DE1,
  output logic                     DE2,
  output logic                     DE3,
  output logic [$clog2(DEPTH)-1:0] Set_idx,
  output logic                     Busy,
  output logic                     Step,
  output logic                     Done
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [DWELL_W-1:0] dwell_len;

  logic               transfer;
  logic               wr_en;
  wset_t              wr_entry;
  wset_t              rd_data;
  wset_t              apply_entry;
  logic [AW-1:0]      rd_addr;
  logic               last;
  logic               start_ok;
  logic [DWELL_W-1:0] dwell_first;

  assign Ld_ready = (state == IDLE) && (cnt < CW'(DEPTH));
  assign transfer = Ld_valid && Ld_ready;
  // Clear empties the table, so a coincident entry is dropped rather than written
  assign wr_en    = transfer && !Clear && Rst_n;
  assign wr_entry = '{w1: Ld_w1, w2: Ld_w2, w3: Ld_w3, de: Ld_de};

  // Set_idx points at the final loaded entry (only meaningful in RUN, cnt>=1)
  assign last = (CW'(Set_idx) == cnt - CW'(1));

  // Read address is the index of the set applied at the next step: 0 when
  // starting or wrapping, Set_idx+1 when advancing.
  assign rd_addr = (state == RUN && !last) ? Set_idx + 1'b1 : '0;

  // An empty table still starts if entry 0 arrives on the same edge; Clear
  // empties the table on that edge, so it also suppresses Start.
  assign start_ok = (state == IDLE) && Start && !Clear && ((cnt != '0) || transfer);

  // Entry 0 is still being written when starting from an empty table, so it
  // is taken straight from the load port.
  assign apply_entry = (state == IDLE && cnt == '0) ? wr_entry : rd_data;

  assign dwell_first = (Dwell == '0) ? DWELL_W'(1) : Dwell;

  weight_set_mem #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_mem (
    .Clk    (Clk),
    .wr_en  (wr_en),
    .wr_addr(cnt[AW-1:0]),
    .wr_data(wr_entry),
    .rd_addr(rd_addr),
    .rd_data(rd_data)
  );

  // Playback FSM: table fill count, dwell timing and all registered outputs.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      dwell_cnt <= '0;
      dwell_len <= '0;
      Set_idx   <= '0;
      W1        <= '0;
      W2        <= '0;
      W3        <= '0;
      DE1       <= 1'b0;
      DE2       <= 1'b0;
      DE3       <= 1'b0;
      Busy      <= 1'b0;
      Step      <= 1'b0;
      Done      <= 1'b0;
    end else begin
      Step <= 1'b0;
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (Clear) begin
            cnt <= '0;
          end else if (transfer) begin
            cnt <= cnt + 1'b1;
          end
          if (start_ok) begin
            state     <= RUN;
            Busy      <= 1'b1;
            Step      <= 1'b1;
            Set_idx   <= '0;
            W1        <= apply_entry.w1;
            W2        <= apply_entry.w2;
            W3        <= apply_entry.w3;
            DE1       <= apply_entry.de[0];
            DE2       <= apply_entry.de[1];
            DE3       <= apply_entry.de[2];
            dwell_len <= dwell_first;
            dwell_cnt <= dwell_first;
          end
        end
        RUN: begin
          if (Stop) begin
            // Abort: silence the neuron inputs, no Done
            state   <= IDLE;
            Busy    <= 1'b0;
            Set_idx <= '0;
            W1      <= '0;
            W2      <= '0;
            W3      <= '0;
            DE1     <= 1'b0;
            DE2     <= 1'b0;
            DE3     <= 1'b0;
          end else if (dwell_cnt == DWELL_W'(1)) begin
            if (!last) begin
              Set_idx   <= Set_idx + 1'b1;
              W1        <= apply_entry.w1;
              W2        <= apply_entry.w2;
              W3        <= apply_entry.w3;
              DE1       <= apply_entry.de[0];
              DE2       <= apply_entry.de[1];
              DE3       <= apply_entry.de[2];
              Step      <= 1'b1;
              dwell_cnt <= dwell_len;
            end else begin
`ifdef NEURON_WSEQ_LOOP_EN
              // Wrap to entry 0 and keep playing
              Set_idx   <= '0;
              W1        <= apply_entry.w1;
              W2        <= apply_entry.w2;
              W3        <= apply_entry.w3;
              DE1       <= apply_entry.de[0];
              DE2       <= apply_entry.de[1];
              DE3       <= apply_entry.de[2];
              Step      <= 1'b1;
              Done      <= 1'b1;
              dwell_cnt <= dwell_len;
`else
              // End of sequence: back to idle with silent outputs
              state   <= IDLE;
              Busy    <= 1'b0;
              Done    <= 1'b1;
              Set_idx <= '0;
              W1      <= '0;
              W2      <= '0;
              W3      <= '0;
              DE1     <= 1'b0;
              DE2     <= 1'b0;
              DE3     <= 1'b0;
`endif
            end
          end else begin
            dwell_cnt <= dwell_cnt - 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_weight_sequencer.sv
// tb_neuron_weight_sequencer: directed stimulus with a cycle-level model of
// the playback timeline (entry k shown from t+1+k*D) checked every cycle,
// plus literal expectations taken from hand-worked scenarios.
module tb_neuron_weight_sequencer;

  localparam int WIDTH   = 4;
  localparam int DEPTH   = 8;
  localparam int DWELL_W = 8;
`ifdef NEURON_WSEQ_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic             Clk, Rst_n, Ld_valid, Ld_ready, Clear, Start, Stop;
  logic [WIDTH-1:0] Ld_w1, Ld_w2, Ld_w3, W1, W2, W3;
  logic [2:0]       Ld_de, Set_idx;
  logic [DWELL_W-1:0] Dwell;
  logic             DE1, DE2, DE3, Busy, Step, Done;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;

  neuron_weight_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .DWELL_W(DWELL_W)
  ) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Ld_valid(Ld_valid), .Ld_ready(Ld_ready),
    .Ld_w1(Ld_w1), .Ld_w2(Ld_w2), .Ld_w3(Ld_w3), .Ld_de(Ld_de),
    .Clear(Clear), .Start(Start), .Stop(Stop), .Dwell(Dwell),
    .W1(W1), .W2(W2), .W3(W3), .DE1(DE1), .DE2(DE2), .DE3(DE3),
    .Set_idx(Set_idx), .Busy(Busy), .Step(Step), .Done(Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Model state: loaded table, fill count and the playback timeline.
  logic [3:0] t_w1 [DEPTH];
  logic [3:0] t_w2 [DEPTH];
  logic [3:0] t_w3 [DEPTH];
  logic [2:0] t_de [DEPTH];
  int m_n = 0, m_len = 1, m_D = 1, m_t = 0;
  bit m_run = 0, m_done = 0, armed = 0;

  // Advance the model on each edge, then compare all outputs just after it.
  always @(posedge Clk) begin : model_p
    bit xfer, go;
    int k;
    cyc++;
    if (!Rst_n) begin
      armed  = 1;
      m_run  = 0;
      m_n    = 0;
      m_done = 0;
    end else begin
      m_done = 0;
      if (m_run) begin
        if (Stop) begin
          m_run = 0;
        end else begin
          m_t++;
          if (!LOOP && m_t == m_len * m_D) begin
            m_run  = 0;
            m_done = 1;
          end else if (LOOP && (m_t % (m_len * m_D)) == 0) begin
            m_done = 1;
          end
        end
      end else begin
        xfer = Ld_valid && (m_n < DEPTH);
        go   = Start && !Clear && (m_n > 0 || xfer);
        if (Clear) begin
          m_n = 0;
        end else if (xfer) begin
          t_w1[m_n] = Ld_w1;
          t_w2[m_n] = Ld_w2;
          t_w3[m_n] = Ld_w3;
          t_de[m_n] = Ld_de;
          m_n++;
        end
        if (go) begin
          m_run = 1;
          m_t   = 0;
          m_D   = (Dwell == 0) ? 1 : int'(Dwell);
          m_len = m_n;
        end
      end
    end
    #1;
    if (armed) begin
      if (m_run) begin
        k = (m_t / m_D) % m_len;
        check("w1", W1, t_w1[k]);
        check("w2", W2, t_w2[k]);
        check("w3", W3, t_w3[k]);
        check("de", {DE3, DE2, DE1}, t_de[k]);
        check("busy", Busy, 1);
        check("step", Step, (m_t % m_D) == 0);
        check("set_idx", Set_idx, k);
      end else begin
        check("w1", W1, 0);
        check("w2", W2, 0);
        check("w3", W3, 0);
        check("de", {DE3, DE2, DE1}, 0);
        check("busy", Busy, 0);
        check("step", Step, 0);
      end
      check("done", Done, m_done);
      check("ld_ready", Ld_ready, !m_run && (m_n < DEPTH));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge Clk);
  endtask

  task automatic load(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c, input logic [2:0] d);
    Ld_valid = 1'b1; Ld_w1 = a; Ld_w2 = b; Ld_w3 = c; Ld_de = d;
    tick();
    Ld_valid = 1'b0;
  endtask

  // Start on the next edge; returns at t+1
  task automatic start_run(input logic [7:0] d);
    Start = 1'b1; Dwell = d;
    tick();
    Start = 1'b0;
  endtask

  task automatic stop_run();
    Stop = 1'b1; tick(); Stop = 1'b0;
  endtask

  task automatic clear_tab();
    Clear = 1'b1; tick(); Clear = 1'b0;
  endtask

  initial begin
    Rst_n = 1'b0; Ld_valid = 1'b0; Clear = 1'b0; Start = 1'b0; Stop = 1'b0;
    Ld_w1 = '0; Ld_w2 = '0; Ld_w3 = '0; Ld_de = '0; Dwell = '0;
    tick(2);
    check("rst_busy", Busy, 0);
    check("rst_w1", W1, 0);
    check("rst_done", Done, 0);
    check("rst_ready", Ld_ready, 1);
    Rst_n = 1'b1;

    // Fill the table; a ninth offer must be ignored
    for (int i = 0; i < DEPTH; i++) load(4'(i + 1), 4'(i + 2), 4'(15 - i), 3'(i));
    check("full_ready", Ld_ready, 0);
    load(4'hF, 4'hF, 4'hF, 3'h7);
    start_run(8'd1);
    check("full_t1_w1", W1, 4'h1);
    tick(7);
    check("full_t8_w1", W1, 4'h8);
    tick();
    check("full_t9_done", Done, 1);
    stop_run();
    clear_tab();
    check("clr_ready", Ld_ready, 1);

    // Three sets, dwell 10
    load(4'h8, 4'h4, 4'hF, 3'b111);
    load(4'h7, 4'h3, 4'h7, 3'b111);
    load(4'h0, 4'h0, 4'h0, 3'b111);
    start_run(8'd10);
    check("d10_t1_w1", W1, 4'h8);
    check("d10_t1_w2", W2, 4'h4);
    check("d10_t1_w3", W3, 4'hF);
    check("d10_t1_step", Step, 1);
    tick(3);
    // Start, Clear, load and Dwell during RUN are all ignored
    Start = 1'b1; Clear = 1'b1; Ld_valid = 1'b1; Dwell = 8'd2;
    tick();
    Start = 1'b0; Clear = 1'b0; Ld_valid = 1'b0;
    tick(6);
    check("d10_t11_w1", W1, 4'h7);
    check("d10_t11_w3", W3, 4'h7);
    tick(10);
    check("d10_t21_w1", W1, 4'h0);
    check("d10_t21_de", {DE3, DE2, DE1}, 3'b111);
    tick(10);
    check("d10_t31_done", Done, 1);
`ifdef NEURON_WSEQ_LOOP_EN
    check("d10_t31_busy", Busy, 1);
    check("d10_t31_w1", W1, 4'h8);
`else
    check("d10_t31_busy", Busy, 0);
    check("d10_t31_de", {DE3, DE2, DE1}, 3'b000);
`endif
    stop_run();

    // Stop at t+15, then replay from entry 0
    start_run(8'd10);
    tick(14);
    Stop = 1'b1;
    tick();
    Stop = 1'b0;
    check("stop_w1", W1, 0);
    check("stop_busy", Busy, 0);
    check("stop_done", Done, 0);
    start_run(8'd10);
    check("replay_w1", W1, 4'h8);
    stop_run();

    // Clear with a simultaneous load drops the entry; Start on empty ignored
    Clear = 1'b1; Ld_valid = 1'b1; Ld_w1 = 4'h5;
    tick();
    Clear = 1'b0; Ld_valid = 1'b0;
    start_run(8'd4);
    check("empty_busy", Busy, 0);
    check("empty_step", Step, 0);

    // Dwell 0 behaves as 1
    load(4'h5, 4'h6, 4'h7, 3'b101);
    load(4'h1, 4'h2, 4'h3, 3'b010);
    start_run(8'd0);
    check("d0_t1_w1", W1, 4'h5);
    check("d0_t1_de", {DE3, DE2, DE1}, 3'b101);
    tick();
    check("d0_t2_w1", W1, 4'h1);
    tick();
    check("d0_t3_done", Done, 1);
    stop_run();

    // Start with a same-edge single load into an empty table
    clear_tab();
    Start = 1'b1; Dwell = 8'd3; Ld_valid = 1'b1;
    Ld_w1 = 4'h9; Ld_w2 = 4'hA; Ld_w3 = 4'hB; Ld_de = 3'b110;
    tick();
    Start = 1'b0; Ld_valid = 1'b0;
    check("same_w1", W1, 4'h9);
    check("same_w3", W3, 4'hB);
    check("same_de", {DE3, DE2, DE1}, 3'b110);
    check("same_step", Step, 1);
    tick(3);
    check("same_t4_done", Done, 1);
    stop_run();

`ifdef NEURON_WSEQ_LOOP_EN
    clear_tab();
    load(4'h3, 4'h3, 4'h3, 3'b001);
    load(4'hC, 4'hC, 4'hC, 3'b100);
    start_run(8'd5);
    check("loop_t1_idx", Set_idx, 0);
    tick(5);
    check("loop_t6_idx", Set_idx, 1);
    tick(5);
    check("loop_t11_idx", Set_idx, 0);
    check("loop_t11_done", Done, 1);
    check("loop_t11_step", Step, 1);
    tick(10);
    check("loop_t21_done", Done, 1);
    check("loop_t21_busy", Busy, 1);
    stop_run();
    start_run(8'd5);
    tick(12);
    Rst_n = 1'b0;
    tick();
    check("loop_rst_w1", W1, 0);
    check("loop_rst_busy", Busy, 0);
    check("loop_rst_de", {DE3, DE2, DE1}, 3'b000);
    Rst_n = 1'b1;
`endif

    tick(2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/neuron_weight_sequencer.md
# neuron_weight_sequencer

Feeds the neuron stage with its synaptic weight vectors (W1..W3) and dendrite enables (DE1..DE3) from a small on-chip table of weight sets. It plays each set back for a programmable dwell time. The block sits directly upstream of the neuron and replaces the hand-driven weight schedule with a loadable, cycle-exact sequence. Sets are written through a valid/ready load port while idle, then replayed on Start.

## Interface
- WIDTH, 4, bits per weight
- DEPTH, 8, number of weight-set entries
- DWELL_W, 8, width of dwell counter
- Clk  in  1  clock, all logic on rising edge
- Rst_n  in  1  synchronous, active-low reset
- Ld_valid  in  1  load entry offered
- Ld_ready  out  1  entry can be accepted
- Ld_w1, Ld_w2, Ld_w3  in  WIDTH  weights of offered entry
- Ld_de  in  3  enables of offered entry, bit0→DE1
- Clear  in  1  empty the table (idle only)
- Start  in  1  begin playback
- Stop  in  1  abort playback
- Dwell  in  DWELL_W  cycles each set is held, sampled at Start
- W1, W2, W3  out  WIDTH  weights to neuron
- DE1, DE2, DE3  out  1  dendrite enables to neuron
- Set_idx  out  $clog2(DEPTH)  index of applied set
- Busy  out  1  playback active
- Step  out  1  one-cycle pulse when a new set is applied
- Done  out  1  one-cycle pulse at end of sequence

## Operation
- States: IDLE, RUN.
- Entry count register `cnt` ranges over 0..DEPTH.
- Load handshake:
  - Ld_ready = (state==IDLE) && (cnt<DEPTH), decoded from registers.
  - Transfer when Ld_valid && Ld_ready: the entry is written at index cnt, then cnt+1.
  - Ld_valid while not ready is ignored. No back-pressure state is kept.
- Clear in IDLE sets cnt=0. Clear in RUN is ignored. Clear with a simultaneous transfer: Clear wins and the entry is dropped.
- IDLE→RUN on Start when the table is non-empty:
  - Condition is cnt>0, or cnt==0 with a same-cycle transfer. A same-cycle load is included in the sequence.
  - On entry: Set_idx=0, outputs take entry 0, Step=1, dwell counter = max(Dwell,1).
  - Start when empty is ignored, with no pulse.
- In RUN, the dwell counter decrements each cycle. When it reaches 1:
  - If Set_idx<cnt-1: advance Set_idx, apply the next entry, pulse Step, reload the counter.
  - If Set_idx==cnt-1: end of sequence (see Configuration).
- Stop in RUN → IDLE. Outputs W*/DE* are zeroed and Done is not pulsed. Stop wins over a same-cycle step or end.
- Start and Stop in IDLE at the same time: Start wins. Stop in IDLE otherwise has no effect.
- Start in RUN is ignored.
- Idle outputs: W1..W3=0, DE1..DE3=0, so the neuron sees no input.

## Timing
- Reset (Rst_n=0 at an edge), regardless of state:
  - State=IDLE, cnt=0, Set_idx=0.
  - W*/DE*/Busy/Step/Done all 0.
  - Ld_ready=1 from the first cycle after reset.
  - Table contents are not reset and are unreachable since cnt=0.
- Reset mid-playback aborts immediately, with no Done.
- All outputs except Ld_ready are registered.
- Start sampled at edge t gives W*/DE*=entry 0, Busy=1 and Step=1 at t+1.
- Entry k is applied at t+1+k·D, where D=max(Dwell,1).
- End of sequence at t+1+cnt·D: Done=1, Busy=0, W*/DE*=0 in the same cycle.
- Dwell changes during RUN have no effect.
- Load-to-Start turnaround is zero cycles (same-edge allowed).

## Configuration
- Macro: NEURON_WSEQ_LOOP_EN.
- Defined:
  - At end of sequence, wrap to Set_idx=0, apply entry 0, and pulse both Step and Done.
  - Busy stays 1.
  - Playback continues until Stop or reset.
- Undefined: end of sequence returns to IDLE as described under Timing.
- Ports are identical in both builds.

## Structure
- Shared package `neuron_pkg`:
  - State enum (IDLE, RUN).
  - Default WIDTH/DEPTH localparams.
  - Packed struct `wset_t` {w1, w2, w3, de[2:0]}.
- Sub-module `weight_set_mem`:
  - DEPTH×wset_t register file.
  - One synchronous write port.
  - One asynchronous read port indexed by the next Set_idx, so applied outputs are registered in the sequencer.
- Sequencer top holds the FSM, cnt, dwell counter, Set_idx and output registers.

## Test plan
- Reset then Ld_valid with no Start → Ld_ready=1. Load DEPTH entries, then the next cycle Ld_ready=0 and a 9th Ld_valid is not written (cnt stays 8).
- Load three entries, then Start with Dwell=10:
  - Entries are (8,4,F,DE=111), (7,3,7,111), (0,0,0,111).
  - W=8/4/F at t+1, 7/3/7 at t+11, 0/0/0 at t+21.
  - Done at t+31, with W*/DE*=0 and Busy=0.
  - Step at t+1, t+11, t+21.
- Dwell=0 with 2 entries → each held 1 cycle, Done at t+3.
- Stop asserted at t+15 of the previous run → t+16 outputs 0, Busy=0, no Done. Start again replays from entry 0.
- Start with cnt=0 and no load → stays IDLE, no Step. Start with a simultaneous single load → entry 0 applied at t+1.
- NEURON_WSEQ_LOOP_EN, 2 entries, Dwell=5 → Set_idx 0,1,0,1…, Done at t+11 and t+21, Busy held. Rst_n=0 at t+13 → all outputs 0 at t+14.
